dma_read_port: RTL and testbench

DMA_READ_PORT -- requirements
Module: dma_read_port

---
 rtl/dmaRegConfigPkg.sv | 36 +++
 rtl/dma_status_reg.sv | 26 ++
 rtl/dma_read_port.sv | 121 ++++++++++++
 tb/tb_dma_read_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmaRegConfigPkg.sv
// Shared address codes, FSM state and read-snapshot types for the DMA register read port.
package dmaRegConfigPkg;

    localparam logic [3:0] ADDR_STATUS = 4'b1000;
    localparam logic [3:0] ADDR_TEMP   = 4'b1101;

    typedef enum logic {
        ST_IDLE,
        ST_DRIVE
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CHAN,
        SRC_STATUS,
        SRC_TEMP
    } src_t;

    typedef struct packed {
        src_t       src;
        logic [7:0] data;
    } rd_snap_t;

    function automatic src_t decode_src(input logic [3:0] a);
        src_t s;
        s = SRC_NONE;
        if (!a[3])
            s = SRC_CHAN;
        else if (a == ADDR_STATUS)
            s = SRC_STATUS;
        else if (a == ADDR_TEMP)
            s = SRC_TEMP;
        return s;
    endfunction

endpackage

// File: rtl/dma_status_reg.sv
// Terminal-count flags: per-channel set on tcPulse, cleared selectively by a status read.
module dma_status_reg (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] set_mask,
    input  logic       clr_en,
    input  logic [3:0] clr_mask,
    input  logic       mclr,
    output logic [3:0] tc_flags
);

    logic [3:0] clr_bits;

    assign clr_bits = clr_en ? clr_mask : 4'h0;

    // A same-cycle set survives the read clear; master clear beats everything.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            tc_flags <= 4'h0;
        else if (mclr)
            tc_flags <= 4'h0;
        else
            tc_flags <= (tc_flags & ~clr_bits) | set_mask;
    end

endmodule

// File: rtl/dma_read_port.sv
// CPU read side of the DMA controller: register decode, snapshot-and-drive FSM, byte pointer.
module dma_read_port
    import dmaRegConfigPkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CS_N,
    input  logic             IOR_N,
    input  logic             HLDA,
    input  logic [3:0]       A,
    input  logic [3:0][15:0] currAddr,
    input  logic [3:0][15:0] currWordCount,
    input  logic [7:0]       tempReg,
    input  logic [3:0]       tcPulse,
    input  logic [3:0]       dreqPending,
    input  logic             wrToggle,
    input  logic             clearFF,
    input  logic             masterClear,
    output logic [7:0]       DB_OUT,
    output logic             DB_OE,
    output logic             byteFF
);

    state_t     state_q, state_d;
    rd_snap_t   snap_q, snap_d;
    src_t       src_sel;
    logic [15:0] word_sel;
    logic [7:0] rd_data;
    logic [3:0] tc_flags;
    logic       read_cond;
    logic       ior_gap_q;
    logic       start_rd;
    logic       rd_toggle;
    logic       st_clr;

    assign read_cond = !CS_N && !IOR_N && !HLDA;
    assign src_sel   = decode_src(A);
    assign word_sel  = A[0] ? currWordCount[A[2:1]] : currAddr[A[2:1]];

    always_comb begin
        rd_data = 8'h00;
        case (src_sel)
            SRC_CHAN:   rd_data = byteFF ? word_sel[15:8] : word_sel[7:0];
            SRC_STATUS: rd_data = {dreqPending, tc_flags};
            SRC_TEMP:   rd_data = tempReg;
            default:    rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        rd_toggle = 1'b0;
        st_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Unreadable codes never leave IDLE and leave no trace.
                if (!masterClear && read_cond && ior_gap_q && src_sel != SRC_NONE) begin
                    state_d = ST_DRIVE;
                    snap_d  = '{src: src_sel, data: rd_data};
                end
            end
            ST_DRIVE: begin
                if (masterClear || HLDA) begin
                    state_d = ST_IDLE;
                end else if (CS_N || IOR_N) begin
                    state_d   = ST_IDLE;
                    rd_toggle = (snap_q.src == SRC_CHAN);
                    st_clr    = (snap_q.src == SRC_STATUS);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign start_rd = (state_q == ST_IDLE) && (state_d == ST_DRIVE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
        end
    end

    // IOR_N must be seen high between reads before another one may start.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            ior_gap_q <= 1'b0;
        else if (start_rd)
            ior_gap_q <= 1'b0;
        else if (IOR_N)
            ior_gap_q <= 1'b1;
    end

    // Simultaneous write-side and read-end toggles cancel out.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            byteFF <= 1'b0;
        else if (clearFF || masterClear)
            byteFF <= 1'b0;
        else if (wrToggle ^ rd_toggle)
            byteFF <= ~byteFF;
    end

    dma_status_reg u_status (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .set_mask (tcPulse),
        .clr_en   (st_clr),
        .clr_mask (snap_q.data[3:0]),
        .mclr     (masterClear),
        .tc_flags (tc_flags)
    );

    assign DB_OUT = snap_q.data;
    assign DB_OE  = (state_q == ST_DRIVE);

endmodule

// File: tb/tb_dma_read_port.sv
// Self-checking bench for dma_read_port: directed scenarios plus a randomized transaction model.
module tb_dma_read_port;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             CS_N;
    logic             IOR_N;
    logic             HLDA;
    logic [3:0]       A;
    logic [3:0][15:0] currAddr;
    logic [3:0][15:0] currWordCount;
    logic [7:0]       tempReg;
    logic [3:0]       tcPulse;
    logic [3:0]       dreqPending;
    logic             wrToggle;
    logic             clearFF;
    logic             masterClear;
    logic [7:0]       DB_OUT;
    logic             DB_OE;
    logic             byteFF;

    int checks = 0;
    int errors = 0;

    dma_read_port dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .CS_N          (CS_N),
        .IOR_N         (IOR_N),
        .HLDA          (HLDA),
        .A             (A),
        .currAddr      (currAddr),
        .currWordCount (currWordCount),
        .tempReg       (tempReg),
        .tcPulse       (tcPulse),
        .dreqPending   (dreqPending),
        .wrToggle      (wrToggle),
        .clearFF       (clearFF),
        .masterClear   (masterClear),
        .DB_OUT        (DB_OUT),
        .DB_OE         (DB_OE),
        .byteFF        (byteFF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic bus_idle();
        CS_N = 1'b1; IOR_N = 1'b1; HLDA = 1'b0;
        tcPulse = 4'h0; wrToggle = 1'b0; clearFF = 1'b0; masterClear = 1'b0;
    endtask

    task automatic start_read(input logic [3:0] a);
        A = a; CS_N = 1'b0; IOR_N = 1'b0;
        tick();
    endtask

    task automatic end_read();
        CS_N = 1'b1; IOR_N = 1'b1;
        tick();
    endtask

    task automatic status_read(input logic [3:0] dreq, output logic [7:0] d, output logic oe);
        dreqPending = dreq;
        start_read(4'b1000);
        d = DB_OUT; oe = DB_OE;
        end_read();
    endtask

    task automatic test_reset();
        logic [7:0] d; logic oe;
        bus_idle();
        A = 4'h0; currAddr = '0; currWordCount = '0; tempReg = 8'h00; dreqPending = 4'h0;
        RESET_N = 1'b0;
        tick(); tick();
        checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", DB_OE); end
        checks++; if (DB_OUT !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", DB_OUT); end
        checks++; if (byteFF !== 1'b0) begin errors++; $display("FAIL reset_byteff got %b exp 0", byteFF); end
        RESET_N = 1'b1;
        tick();
        status_read(4'h0, d, oe);
        checks++; if (oe !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL reset_status got oe=%b d=%h exp oe=1 d=00", oe, d); end
    endtask

    task automatic test_chan_read();
        currAddr[1] = 16'hCC88;
        A = 4'b0010; CS_N = 1'b0; IOR_N = 1'b0;
        #1;
        checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL chan_latency got oe=%b exp 0", DB_OE); end
        tick();
        checks++; if (DB_OE !== 1'b1 || DB_OUT !== 8'h88) begin errors++; $display("FAIL chan_lo got oe=%b d=%h exp oe=1 d=88", DB_OE, DB_OUT); end
        currAddr[1] = 16'h1234; A = 4'b1000;
        tick();
        checks++; if (DB_OUT !== 8'h88) begin errors++; $display("FAIL chan_hold got %h exp 88", DB_OUT); end
        end_read();
        checks++; if (DB_OE !== 1'b0 || byteFF !== 1'b1) begin errors++; $display("FAIL chan_end1 got oe=%b ff=%b exp oe=0 ff=1", DB_OE, byteFF); end
        currAddr[1] = 16'hCC88;
        start_read(4'b0010);
        checks++; if (DB_OE !== 1'b1 || DB_OUT !== 8'hCC) begin errors++; $display("FAIL chan_hi got oe=%b d=%h exp oe=1 d=cc", DB_OE, DB_OUT); end
        end_read();
        checks++; if (byteFF !== 1'b0) begin errors++; $display("FAIL chan_end2 got ff=%b exp 0", byteFF); end
    endtask

    task automatic test_status();
        logic [7:0] d; logic oe;
        tcPulse = 4'b0101; tick(); tcPulse = 4'h0;
        status_read(4'b0010, d, oe);
        checks++; if (oe !== 1'b1 || d !== 8'h25) begin errors++; $display("FAIL status_read got oe=%b d=%h exp oe=1 d=25", oe, d); end
        status_read(4'b0010, d, oe);
        checks++; if (d !== 8'h20) begin errors++; $display("FAIL status_cleared got %h exp 20", d); end
    endtask

    task automatic test_tc_during_read();
        logic [7:0] d; logic oe;
        tcPulse = 4'b0001; tick(); tcPulse = 4'h0;
        dreqPending = 4'h0;
        start_read(4'b1000);
        checks++; if (DB_OUT !== 8'h01) begin errors++; $display("FAIL tcdrv_snap got %h exp 01", DB_OUT); end
        tcPulse = 4'b1000; tick(); tcPulse = 4'h0;
        end_read();
        status_read(4'h0, d, oe);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL tcdrv_after got %h exp 08", d); end
    endtask

    task automatic test_abort();
        currWordCount[0] = 16'hA55A;
        start_read(4'b0001);
        checks++; if (DB_OE !== 1'b1 || DB_OUT !== 8'h5A) begin errors++; $display("FAIL abort_start got oe=%b d=%h exp oe=1 d=5a", DB_OE, DB_OUT); end
        HLDA = 1'b1; tick();
        checks++; if (DB_OE !== 1'b0 || byteFF !== 1'b0) begin errors++; $display("FAIL abort_end got oe=%b ff=%b exp oe=0 ff=0", DB_OE, byteFF); end
        HLDA = 1'b0; tick();
        checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL abort_nogap got oe=%b exp 0", DB_OE); end
        end_read();
    endtask

    task automatic test_clear_ff();
        wrToggle = 1'b1; tick(); wrToggle = 1'b0;
        checks++; if (byteFF !== 1'b1) begin errors++; $display("FAIL wrtoggle got %b exp 1", byteFF); end
        clearFF = 1'b1; wrToggle = 1'b1; tick(); clearFF = 1'b0; wrToggle = 1'b0;
        checks++; if (byteFF !== 1'b0) begin errors++; $display("FAIL clearff_wins got %b exp 0", byteFF); end
        start_read(4'b1111);
        checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL unreadable_oe got %b exp 0", DB_OE); end
        tick();
        checks++; if (DB_OE !== 1'b0 || byteFF !== 1'b0) begin errors++; $display("FAIL unreadable_hold got oe=%b ff=%b exp 0 0", DB_OE, byteFF); end
        end_read();
    endtask

    task automatic test_toggle_collision();
        start_read(4'b0000);
        CS_N = 1'b1; IOR_N = 1'b1; wrToggle = 1'b1; tick(); wrToggle = 1'b0;
        checks++; if (byteFF !== 1'b0 || DB_OE !== 1'b0) begin errors++; $display("FAIL toggle_cancel got ff=%b oe=%b exp 0 0", byteFF, DB_OE); end
    endtask

    task automatic test_master_clear();
        logic [7:0] d; logic oe;
        tcPulse = 4'b0011; tick();
        masterClear = 1'b1; tcPulse = 4'b0100; tick();
        masterClear = 1'b0; tcPulse = 4'h0;
        status_read(4'h0, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mclr_tc got %h exp 00", d); end
        wrToggle = 1'b1; tick(); wrToggle = 1'b0;
        start_read(4'b0000);
        masterClear = 1'b1; tick(); masterClear = 1'b0;
        checks++; if (DB_OE !== 1'b0 || byteFF !== 1'b0) begin errors++; $display("FAIL mclr_read got oe=%b ff=%b exp 0 0", DB_OE, byteFF); end
        end_read();
    endtask

    task automatic test_back_to_back();
        start_read(4'b0000);
        CS_N = 1'b1; tick();
        checks++; if (DB_OE !== 1'b0 || byteFF !== 1'b1) begin errors++; $display("FAIL b2b_csend got oe=%b ff=%b exp 0 1", DB_OE, byteFF); end
        CS_N = 1'b0; tick(); tick();
        checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL b2b_nogap got %b exp 0", DB_OE); end
        IOR_N = 1'b1; tick(); IOR_N = 1'b0; tick();
        checks++; if (DB_OE !== 1'b1) begin errors++; $display("FAIL b2b_gap got %b exp 1", DB_OE); end
        end_read();
        checks++; if (byteFF !== 1'b0) begin errors++; $display("FAIL b2b_ff got %b exp 0", byteFF); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d; logic oe;
        tcPulse = 4'b0110; tick(); tcPulse = 4'h0;
        dreqPending = 4'b1001;
        start_read(4'b1000);
        checks++; if (DB_OUT !== 8'h96) begin errors++; $display("FAIL rstmid_snap got %h exp 96", DB_OUT); end
        #2 RESET_N = 1'b0;
        #1;
        checks++; if (DB_OE !== 1'b0) begin errors++; $display("FAIL rstmid_async_oe got %b exp 0", DB_OE); end
        bus_idle();
        tick();
        RESET_N = 1'b1;
        tick();
        status_read(4'h0, d, oe);
        checks++; if (d !== 8'h00 || byteFF !== 1'b0) begin errors++; $display("FAIL rstmid_after got d=%h ff=%b exp 00 0", d, byteFF); end
    endtask

    task automatic test_random();
        logic [3:0] bad [6];
        logic [3:0] a, p, p2;
        logic [7:0] exp_d, d;
        logic       exp_oe, w, oe, is_chan;
        logic       m_bf;
        logic [3:0] m_tc;
        logic [15:0] word;
        bad = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};
        masterClear = 1'b1; tick(); masterClear = 1'b0;
        m_bf = 1'b0; m_tc = 4'h0;
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 4; k++) begin
                currAddr[k] = 16'($urandom); currWordCount[k] = 16'($urandom);
            end
            tempReg = 8'($urandom); dreqPending = 4'($urandom);
            p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            tcPulse = p; tick(); tcPulse = 4'h0;
            m_tc = m_tc | p;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = {1'b0, 3'($urandom)};
                6, 7:             a = 4'b1000;
                8:                a = 4'b1101;
                default:          a = bad[$urandom_range(0, 5)];
            endcase
            word    = a[0] ? currWordCount[a[2:1]] : currAddr[a[2:1]];
            is_chan = !a[3];
            exp_oe  = 1'b1;
            if (is_chan)           exp_d = m_bf ? word[15:8] : word[7:0];
            else if (a == 4'b1000) exp_d = {dreqPending, m_tc};
            else if (a == 4'b1101) exp_d = tempReg;
            else begin exp_d = 8'h00; exp_oe = 1'b0; end
            start_read(a);
            checks++; if (DB_OE !== exp_oe) begin errors++; $display("FAIL rnd_oe[%0d] a=%b got %b exp %b", i, a, DB_OE, exp_oe); end
            if (exp_oe) begin
                checks++; if (DB_OUT !== exp_d) begin errors++; $display("FAIL rnd_data[%0d] a=%b got %h exp %h", i, a, DB_OUT, exp_d); end
            end
            currAddr = {$urandom, $urandom}; currWordCount = {$urandom, $urandom};
            tempReg = 8'($urandom); dreqPending = 4'($urandom);
            tick();
            if (exp_oe) begin
                checks++; if (DB_OUT !== exp_d || DB_OE !== 1'b1) begin errors++; $display("FAIL rnd_hold[%0d] got oe=%b d=%h exp 1 %h", i, DB_OE, DB_OUT, exp_d); end
            end
            p2 = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            w  = 1'($urandom_range(0, 1));
            CS_N = 1'b1; IOR_N = 1'b1; tcPulse = p2; wrToggle = w;
            tick();
            tcPulse = 4'h0; wrToggle = 1'b0;
            if (exp_oe && a == 4'b1000) m_tc = (m_tc & ~exp_d[3:0]) | p2;
            else                        m_tc = m_tc | p2;
            m_bf = m_bf ^ w ^ (exp_oe && is_chan);
            checks++; if (byteFF !== m_bf || DB_OE !== 1'b0) begin errors++; $display("FAIL rnd_end[%0d] got ff=%b oe=%b exp ff=%b oe=0", i, byteFF, DB_OE, m_bf); end
        end
        status_read(4'h0, d, oe);
        checks++; if (d !== {4'h0, m_tc}) begin errors++; $display("FAIL rnd_final_tc got %h exp %h", d, {4'h0, m_tc}); end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout reached, got no finish, exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_chan_read();
        test_status();
        test_tc_during_read();
        test_abort();
        test_clear_ff();
        test_toggle_collision();
        test_master_clear();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
